// File: rtl/priority_arbiter_rr.sv
// Registered N-way arbiter with run-time fixed-priority / round-robin modes.
// A grant is held until it is acknowledged or the winning requester withdraws.
module priority_arbiter_rr #(
   parameter  int unsigned N     = 8,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [N-1:0]     req,
   input  logic             ack,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       gnt_q, gnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               valid_q, valid_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;

   logic               ack_cycle;
   logic               any_req;
   logic [IDX_W-1:0]   ptr_after_ack;
   logic [IDX_W-1:0]   ptr_arb;
   logic [IDX_W-1:0]   fix_idx;
   logic [IDX_W-1:0]   rr_lo_idx;
   logic [IDX_W-1:0]   rr_ge_idx;
   logic               rr_ge_hit;
   logic [IDX_W-1:0]   win_idx;

   assign ack_cycle     = (state_q == GRANT) && ack;
   assign any_req       = |req;
   assign ptr_after_ack = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);

   // Re-arbitration on an ack must already see the advanced pointer.
   assign ptr_arb = (ack_cycle && mode) ? ptr_after_ack : ptr_q;

   always_comb begin
      fix_idx   = '0;
      rr_lo_idx = '0;
      rr_ge_idx = '0;
      rr_ge_hit = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i]) fix_idx = IDX_W'(i);
      end
      // Descending scan: the last hit is the lowest set index.
      for (int unsigned i = N; i > 0; i--) begin
         if (req[i-1]) begin
            rr_lo_idx = IDX_W'(i - 1);
            if (IDX_W'(i - 1) >= ptr_arb) begin
               rr_ge_idx = IDX_W'(i - 1);
               rr_ge_hit = 1'b1;
            end
         end
      end
      if (mode) win_idx = rr_ge_hit ? rr_ge_idx : rr_lo_idx;
      else      win_idx = fix_idx;
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (en && any_req) begin
               state_d = GRANT;
               gnt_d   = N'(1) << win_idx;
               idx_d   = win_idx;
               valid_d = 1'b1;
            end
         end
         GRANT: begin
            if (ack) begin
               if (mode) ptr_d = ptr_after_ack;
               if (en && any_req) begin
                  gnt_d = N'(1) << win_idx;
                  idx_d = win_idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  idx_d   = '0;
                  valid_d = 1'b0;
               end
            end else if (!req[idx_q]) begin
               state_d = IDLE;
               gnt_d   = '0;
               idx_d   = '0;
               valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt   = gnt_q;
   assign idx   = idx_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Bench for priority_arbiter_rr (N=8): directed scenarios followed by random
// cycles, every cycle scored against a behavioural model through a queue.
module tb_priority_arbiter_rr;

   localparam int unsigned N     = 8;
   localparam int unsigned IDX_W = 3;

   typedef struct {
      logic             v;
      logic [IDX_W-1:0] i;
      logic [N-1:0]     g;
      logic             chk_idx;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst, en, mode, ack;
   logic [N-1:0]     req;
   logic [N-1:0]     gnt;
   logic [IDX_W-1:0] idx;
   logic             valid;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic             m_valid;
   logic [IDX_W-1:0] m_idx;
   logic [IDX_W-1:0] m_ptr;
   exp_t             sb[$];

   always #5 clk = ~clk;

   priority_arbiter_rr #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (mode),
      .req   (req),
      .ack   (ack),
      .gnt   (gnt),
      .idx   (idx),
      .valid (valid)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns {found, index}; round-robin walks forward from the pointer.
   function automatic logic [IDX_W:0] model_arb(input logic [N-1:0] r, input logic md,
                                               input logic [IDX_W-1:0] p);
      if (!md) begin
         for (int k = N - 1; k >= 0; k--)
            if (r[k]) return {1'b1, IDX_W'(k)};
      end else begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(p) + k) % N;
            if (r[j]) return {1'b1, IDX_W'(j)};
         end
      end
      return '0;
   endfunction

   task automatic step(input logic r, input logic e, input logic md,
                       input logic [N-1:0] rq, input logic a);
      logic [IDX_W:0] w;
      exp_t           x;
      rst  = r;
      en   = e;
      mode = md;
      req  = rq;
      ack  = a;
      if (r) begin
         m_valid = 1'b0;
         m_idx   = '0;
         m_ptr   = '0;
      end else if (!m_valid) begin
         if (e && (rq != '0)) begin
            w       = model_arb(rq, md, m_ptr);
            m_valid = 1'b1;
            m_idx   = w[IDX_W-1:0];
         end
      end else if (a) begin
         if (md) m_ptr = IDX_W'((int'(m_idx) + 1) % N);
         if (e && (rq != '0)) begin
            w     = model_arb(rq, md, m_ptr);
            m_idx = w[IDX_W-1:0];
         end else begin
            m_valid = 1'b0;
            m_idx   = '0;
         end
      end else if (!rq[m_idx]) begin
         m_valid = 1'b0;
         m_idx   = '0;
      end
      x.v       = m_valid;
      x.i       = m_idx;
      x.g       = m_valid ? (N'(1) << m_idx) : '0;
      x.chk_idx = r | m_valid;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("valid", valid, x.v);
      chk("gnt", gnt, x.g);
      if (x.chk_idx) chk("idx", idx, x.i);
      chk("onehot0", $onehot0(gnt), 1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b0; req = '0; ack = 1'b0;
      m_valid = 1'b0; m_idx = '0; m_ptr = '0;

      step(1, 0, 0, 8'h00, 0);
      step(1, 1, 1, 8'hFF, 1);
      chk("reset_valid", valid, 0);
      chk("reset_gnt", gnt, 0);
      chk("reset_idx", idx, 0);

      // fixed priority, hold, then ack re-arbitration
      step(0, 1, 0, 8'h96, 0);
      chk("t1_gnt", gnt, 8'h80);
      chk("t1_idx", idx, 7);
      chk("t1_valid", valid, 1);
      for (int k = 0; k < 5; k++) begin
         step(0, 1, 0, 8'h96, 0);
         chk($sformatf("t1_hold%0d", k), idx, 7);
      end
      step(0, 1, 0, 8'h16, 1);
      chk("t1_ack_idx", idx, 4);
      step(0, 1, 0, 8'h00, 1);
      chk("t1_release", valid, 0);

      // round-robin sweep with continuous ack
      step(0, 1, 1, 8'hFF, 0);
      chk("t2_first", idx, 0);
      for (int k = 0; k < 8; k++) begin
         step(0, 1, 1, 8'hFF, 1);
         chk($sformatf("t2_idx%0d", k), idx, (k + 1) % 8);
         chk($sformatf("t2_valid%0d", k), valid, 1);
      end
      step(0, 1, 1, 8'h00, 1);

      // round-robin wrap-around
      step(0, 1, 1, 8'h20, 0);
      chk("t3_idx5", idx, 5);
      step(0, 1, 1, 8'h03, 1);
      chk("t3_wrap0", idx, 0);
      step(0, 1, 1, 8'h03, 1);
      chk("t3_idx1", idx, 1);
      step(0, 1, 1, 8'h00, 1);
      chk("t3_drop", valid, 0);

      // withdrawal leaves the pointer alone
      step(0, 1, 1, 8'h08, 0);
      chk("t4_idx3", idx, 3);
      step(0, 1, 1, 8'h00, 0);
      chk("t4_wd_valid", valid, 0);
      chk("t4_wd_gnt", gnt, 0);
      step(0, 1, 1, 8'h48, 0);
      chk("t4_regrant", idx, 3);
      step(0, 1, 1, 8'h00, 1);

      // reset mid-grant clears the pointer
      step(0, 1, 0, 8'h40, 0);
      chk("t5_idx6", idx, 6);
      step(1, 1, 0, 8'h40, 0);
      chk("t5_rst_valid", valid, 0);
      chk("t5_rst_gnt", gnt, 0);
      chk("t5_rst_idx", idx, 0);
      step(0, 1, 1, 8'h41, 0);
      chk("t5_after", idx, 0);
      step(0, 1, 1, 8'h00, 1);

      // enable gating
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 8'h0F, 0);
         chk($sformatf("t6_en0_%0d", k), valid, 0);
      end
      step(0, 1, 0, 8'h0F, 0);
      chk("t6_en1", valid, 1);
      chk("t6_idx", idx, 3);
      step(0, 1, 0, 8'h00, 1);

      for (int k = 0; k < 500; k++) begin
         logic [N-1:0] rq;
         rq = N'($urandom);
         if ($urandom_range(0, 2) == 0) rq = rq & N'($urandom);
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), rq, ($urandom_range(0, 2) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
